fea_frame_bank_ctrl: RTL and testbench
======================================

Name: fea_frame_bank_ctrl

Overview:
- Parametrised frame sequencer and feature-count bookkeeper for the N-camera feature pipeline.
- Splits the pixel-valid stream into frames using a minimum-gap rule and assigns each frame to a channel in round-robin order.
- Generates descriptor-RAM write addresses per channel and commits per-set feature counts into a DEPTH-slot ring.
- Presents the current and previous set counts to the matcher.

Parameters:
NUM_CH, 2, channels (frames) per set; must be ≥2.
DEPTH, 5, bank ring depth; must be ≥3.
ADDR_W, 10, descriptor RAM address width; max 2**ADDR_W features per frame.
GAP_MIN, 1, consecutive invalid cycles that end a frame; must be ≥1.
Derived: CH_W=clog2(NUM_CH), BANK_W=clog2(DEPTH), CNT_W=ADDR_W+1.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
din_valid  in  1  pixel valid; a frame is one burst
feat_valid  in  1  detector output valid
feat_flag  in  1  feature present at this output
flush  in  1  commit the partial set now
ovf_clr  in  1  clear overflow flags
wr_en  out  1  descriptor write strobe (combinational)
wr_ch  out  CH_W  channel being written
wr_bank  out  BANK_W  bank being written
wr_addr  out  ADDR_W  slot within the frame
frame_start  out  1  Mealy pulse on the first valid of a frame
set_done  out  1  registered one-cycle pulse after a commit
cur_bank, prev_bank  out  BANK_W  last and second-last committed banks
cur_cnt, prev_cnt  out  NUM_CH*CNT_W  counts; ch0 in the LSBs
cnt_valid, prev_valid  out  1  ≥1 and ≥2 sets committed
ovf  out  NUM_CH  sticky per-channel saturation flag

Behaviour:
- Reset: all outputs 0, state IDLE, ch_idx=0, wbank=0, staging counts 0. Reset mid-frame discards the partial set.
- FSM states:
  - IDLE: din_valid→ACTIVE.
  - ACTIVE: !din_valid→GAP, gap_cnt=1.
  - GAP: din_valid→ACTIVE (same frame). Otherwise gap_cnt++; when gap_cnt reaches GAP_MIN→WAIT.
  - WAIT: din_valid→ACTIVE.
  - With GAP_MIN=1, ACTIVE→WAIT directly.
- frame_start = din_valid && state∈{IDLE,WAIT}.
- Channel index at frame_start: from IDLE ch_idx←0; from WAIT ch_idx←(ch_idx+1) mod NUM_CH. staging[new ch]←0.
- Feature acceptance: accepted when feat_valid && feat_flag && state≠IDLE-before-first-frame.
  - Accepted and staging[ch_idx]<2**ADDR_W: wr_en=1, wr_addr=staging[ch_idx][ADDR_W-1:0], wr_ch=ch_idx, wr_bank=wbank; staging[ch_idx]++.
  - Accepted and saturated: wr_en=0, ovf[ch_idx]←1.
  - Features keep counting to ch_idx through gaps until the next frame_start. A feature in the frame_start cycle belongs to the old ch_idx.
- Commit triggers: frame_start from WAIT with new ch=0, or flush while state≠IDLE.
- Commit actions:
  - bank[wbank]←staging, including any same-cycle increment.
  - prev_bank←cur_bank; cur_bank←wbank; wbank←(wbank+1) mod DEPTH.
  - prev_valid←cnt_valid; cnt_valid←1.
  - set_done=1 next cycle; cur_cnt/prev_cnt update next cycle (registered reads of bank[cur_bank]/bank[prev_bank]).
- Flush: state→IDLE. Next burst starts ch0 without a second commit. Flush in IDLE is ignored. Flush coincident with a ch0 frame_start commits once.
- Bank safety: wbank never equals cur_bank or prev_bank (DEPTH≥3).
- ovf: cleared by ovf_clr. A set event in the same cycle wins over the clear.

Decomposition:
- Package fea_pkg: FSM state enum {IDLE,ACTIVE,GAP,WAIT}, clog2 function, CNT_W derivation, parameter-legality assertions.
- Sub-module frame_gap_det: holds the FSM, gap_cnt, frame_start generation and the next-set indication.
- Parent module holds the counters, ring memory and commit logic.

Test Plan:
1. GAP_MIN=4, NUM_CH=2; bursts of 100 with gaps of 4 → frame_start at cycles 0, 104, 208; ch_idx 0,1,0; set_done at cycle 209.
2. 3-cycle gap inside a burst, GAP_MIN=4 → no frame_start; ch_idx unchanged.
3. 7 features on ch0, 12 on ch1, then ch0 start:
   - wr_addr 0..6 on ch0, 0..11 on ch1.
   - cur_cnt={12,7}, cur_bank=0, cnt_valid=1, prev_valid=0.
   - After the second set: cur_bank=1, prev_bank=0, prev_valid=1.
4. ADDR_W=4, 20 features on ch0 → 16 writes (addr 0..15), count 16, ovf=01. ovf_clr→ovf=00. ovf_clr in the same cycle as a saturated feature → ovf stays 1.
5. Six sets, DEPTH=5 → cur_bank sequence 0,1,2,3,4,0; wr_bank never equals cur_bank or prev_bank.
6. Flush during ch1 with 5 features → commit {5,x}; next burst is ch0 with no extra commit. rst asserted mid-frame → all outputs 0 the next cycle.

Source files
------------

// File: rtl/fea_frame_bank_ctrl_pkg.sv
// Shared types and elaboration helpers for the feature-pipeline frame sequencer.
package fea_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2,
        WAIT   = 2'd3
    } fsm_state_t;

    // Never returns less than one so that single-entry fields still get a bit.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        while ((32'sd1 << width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

    function automatic int cnt_width(input int addr_w);
        return addr_w + 1;
    endfunction

    function automatic bit params_legal(input int num_ch, input int depth,
                                        input int gap_min, input int addr_w);
        return (num_ch >= 2) && (depth >= 3) && (gap_min >= 1) && (addr_w >= 1);
    endfunction

endpackage

// File: rtl/fea_frame_bank_ctrl_frame_gap_det.sv
// Splits the pixel-valid stream into frames with a minimum-gap rule and
// sequences frames onto channels in round-robin order.
module frame_gap_det
    import fea_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int GAP_MIN = 1,
    parameter int CH_W    = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            din_valid,
    input  logic            flush,
    output logic            frame_start,
    output logic            set_wrap,
    output logic            running,
    output logic [CH_W-1:0] ch_idx,
    output logic [CH_W-1:0] new_ch
);

    localparam int GAP_W = clog2(GAP_MIN + 1);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_MIN);

    fsm_state_t       state_r;
    logic [GAP_W-1:0] gap_cnt_r;
    logic [CH_W-1:0]  ch_idx_r;
    logic             from_wait_s;

    assign ch_idx = ch_idx_r;

    // Mealy frame-start decode, next channel and set-wrap indication
    always_comb begin
        from_wait_s = (state_r == WAIT);
        running     = (state_r != IDLE);
        frame_start = din_valid && ((state_r == IDLE) || from_wait_s);
        if (from_wait_s) begin
            new_ch = (ch_idx_r == LAST_CH) ? CH_W'(0) : ch_idx_r + CH_W'(1);
        end else begin
            new_ch = CH_W'(0);
        end
        set_wrap = frame_start && from_wait_s && (ch_idx_r == LAST_CH);
    end

    // Frame FSM; a flush abandons the set and waits for a fresh burst
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            gap_cnt_r <= GAP_W'(0);
            ch_idx_r  <= CH_W'(0);
        end else if (flush && (state_r != IDLE)) begin
            state_r   <= IDLE;
            gap_cnt_r <= GAP_W'(0);
        end else begin
            case (state_r)
                IDLE, WAIT: begin
                    if (din_valid) begin
                        state_r  <= ACTIVE;
                        ch_idx_r <= new_ch;
                    end
                end
                ACTIVE: begin
                    if (!din_valid) begin
                        gap_cnt_r <= GAP_W'(1);
                        state_r   <= (GAP_MIN == 1) ? WAIT : GAP;
                    end
                end
                GAP: begin
                    if (din_valid) begin
                        state_r <= ACTIVE;
                    end else if ((gap_cnt_r + GAP_W'(1)) == GAP_LAST) begin
                        state_r <= WAIT;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + GAP_W'(1);
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/fea_frame_bank_ctrl.sv
// Frame sequencer and per-set feature-count bookkeeper: descriptor write
// addressing, saturation tracking and a DEPTH-slot ring of committed sets.
module fea_frame_bank_ctrl
    import fea_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int DEPTH   = 5,
    parameter int ADDR_W  = 10,
    parameter int GAP_MIN = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               din_valid,
    input  logic                               feat_valid,
    input  logic                               feat_flag,
    input  logic                               flush,
    input  logic                               ovf_clr,
    output logic                               wr_en,
    output logic [clog2(NUM_CH)-1:0]           wr_ch,
    output logic [clog2(DEPTH)-1:0]            wr_bank,
    output logic [ADDR_W-1:0]                  wr_addr,
    output logic                               frame_start,
    output logic                               set_done,
    output logic [clog2(DEPTH)-1:0]            cur_bank,
    output logic [clog2(DEPTH)-1:0]            prev_bank,
    output logic [NUM_CH*cnt_width(ADDR_W)-1:0] cur_cnt,
    output logic [NUM_CH*cnt_width(ADDR_W)-1:0] prev_cnt,
    output logic                               cnt_valid,
    output logic                               prev_valid,
    output logic [NUM_CH-1:0]                  ovf
);

    localparam int CH_W   = clog2(NUM_CH);
    localparam int BANK_W = clog2(DEPTH);
    localparam int CNT_W  = cnt_width(ADDR_W);
    localparam int SET_W  = NUM_CH * CNT_W;

    if (!params_legal(NUM_CH, DEPTH, GAP_MIN, ADDR_W)) begin : g_param_check
        $error("fea_frame_bank_ctrl: illegal parameter combination");
    end

    logic                        set_wrap_s;
    logic                        running_s;
    logic [CH_W-1:0]             ch_idx_s;
    logic [CH_W-1:0]             new_ch_s;
    logic                        accept_s;
    logic                        sat_s;
    logic                        commit_s;
    logic [NUM_CH-1:0][CNT_W-1:0] staging_r;
    logic [NUM_CH-1:0][CNT_W-1:0] stg_inc_s;
    logic [NUM_CH-1:0][CNT_W-1:0] stg_next_s;
    logic [NUM_CH-1:0]           ovf_next_s;
    logic [SET_W-1:0]            bank_r [DEPTH];
    logic [BANK_W-1:0]           wbank_r;
    logic [BANK_W-1:0]           cur_bank_r;
    logic [BANK_W-1:0]           prev_bank_r;
    logic [SET_W-1:0]            cur_cnt_r;
    logic [SET_W-1:0]            prev_cnt_r;
    logic                        cnt_valid_r;
    logic                        prev_valid_r;
    logic                        set_done_r;
    logic [NUM_CH-1:0]           ovf_r;

    frame_gap_det #(
        .NUM_CH  (NUM_CH),
        .GAP_MIN (GAP_MIN),
        .CH_W    (CH_W)
    ) u_gap_det (
        .clk         (clk),
        .rst         (rst),
        .din_valid   (din_valid),
        .flush       (flush),
        .frame_start (frame_start),
        .set_wrap    (set_wrap_s),
        .running     (running_s),
        .ch_idx      (ch_idx_s),
        .new_ch      (new_ch_s)
    );

    // Feature acceptance, descriptor write port and next staging counts
    always_comb begin
        accept_s  = feat_valid && feat_flag && running_s;
        sat_s     = staging_r[ch_idx_s][ADDR_W];
        wr_en     = accept_s && !sat_s;
        wr_ch     = ch_idx_s;
        wr_bank   = wbank_r;
        wr_addr   = staging_r[ch_idx_s][ADDR_W-1:0];
        stg_inc_s = staging_r;
        if (wr_en) begin
            stg_inc_s[ch_idx_s] = staging_r[ch_idx_s] + CNT_W'(1);
        end else begin
            stg_inc_s[ch_idx_s] = staging_r[ch_idx_s];
        end
        commit_s   = set_wrap_s || (flush && running_s);
        stg_next_s = stg_inc_s;
        // A feature in the frame-start cycle still lands in the old channel.
        if (commit_s) begin
            stg_next_s = '0;
        end else if (frame_start) begin
            stg_next_s[new_ch_s] = CNT_W'(0);
        end else begin
            stg_next_s = stg_inc_s;
        end
        ovf_next_s = ovf_clr ? NUM_CH'(0) : ovf_r;
        if (accept_s && sat_s) begin
            ovf_next_s[ch_idx_s] = 1'b1;
        end else begin
            ovf_next_s[ch_idx_s] = ovf_clr ? 1'b0 : ovf_r[ch_idx_s];
        end
    end

    // Staging counters, ring commit and matcher-facing registers
    always_ff @(posedge clk) begin
        if (rst) begin
            staging_r    <= '0;
            wbank_r      <= BANK_W'(0);
            cur_bank_r   <= BANK_W'(0);
            prev_bank_r  <= BANK_W'(0);
            cur_cnt_r    <= SET_W'(0);
            prev_cnt_r   <= SET_W'(0);
            cnt_valid_r  <= 1'b0;
            prev_valid_r <= 1'b0;
            set_done_r   <= 1'b0;
            ovf_r        <= NUM_CH'(0);
            for (int i = 0; i < DEPTH; i++) begin
                bank_r[i] <= SET_W'(0);
            end
        end else begin
            staging_r  <= stg_next_s;
            set_done_r <= commit_s;
            ovf_r      <= ovf_next_s;
            if (commit_s) begin
                bank_r[wbank_r] <= stg_inc_s;
                cur_cnt_r       <= stg_inc_s;
                prev_cnt_r      <= bank_r[cur_bank_r];
                prev_bank_r     <= cur_bank_r;
                cur_bank_r      <= wbank_r;
                wbank_r         <= (wbank_r == BANK_W'(DEPTH - 1)) ? BANK_W'(0)
                                                                   : wbank_r + BANK_W'(1);
                prev_valid_r    <= cnt_valid_r;
                cnt_valid_r     <= 1'b1;
            end
        end
    end

    assign set_done   = set_done_r;
    assign cur_bank   = cur_bank_r;
    assign prev_bank  = prev_bank_r;
    assign cur_cnt    = cur_cnt_r;
    assign prev_cnt   = prev_cnt_r;
    assign cnt_valid  = cnt_valid_r;
    assign prev_valid = prev_valid_r;
    assign ovf        = ovf_r;

endmodule

// File: tb/tb_fea_frame_bank_ctrl.sv
// Directed self-checking bench for fea_frame_bank_ctrl (NUM_CH=2, DEPTH=5,
// ADDR_W=4, GAP_MIN=4); expected values are hand-computed constants.
module tb_fea_frame_bank_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din_valid = 1'b0;
    logic       feat_valid = 1'b0;
    logic       feat_flag = 1'b0;
    logic       flush = 1'b0;
    logic       ovf_clr = 1'b0;
    logic       wr_en;
    logic [0:0] wr_ch;
    logic [2:0] wr_bank;
    logic [3:0] wr_addr;
    logic       frame_start;
    logic       set_done;
    logic [2:0] cur_bank;
    logic [2:0] prev_bank;
    logic [9:0] cur_cnt;
    logic [9:0] prev_cnt;
    logic       cnt_valid;
    logic       prev_valid;
    logic [1:0] ovf;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fea_frame_bank_ctrl #(
        .NUM_CH  (2),
        .DEPTH   (5),
        .ADDR_W  (4),
        .GAP_MIN (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .din_valid   (din_valid),
        .feat_valid  (feat_valid),
        .feat_flag   (feat_flag),
        .flush       (flush),
        .ovf_clr     (ovf_clr),
        .wr_en       (wr_en),
        .wr_ch       (wr_ch),
        .wr_bank     (wr_bank),
        .wr_addr     (wr_addr),
        .frame_start (frame_start),
        .set_done    (set_done),
        .cur_bank    (cur_bank),
        .prev_bank   (prev_bank),
        .cur_cnt     (cur_cnt),
        .prev_cnt    (prev_cnt),
        .cnt_valid   (cnt_valid),
        .prev_valid  (prev_valid),
        .ovf         (ovf)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled 1 unit later.
    task automatic drive(input logic dv, input logic feat, input logic fl, input logic clr);
        din_valid  = dv;
        feat_valid = feat;
        feat_flag  = feat;
        flush      = fl;
        ovf_clr    = clr;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
    endtask

    task automatic start(input string tag);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq({tag, ".frame_start"}, 64'(frame_start), 64'd1);
        tick();
    endtask

    // Features on consecutive valid cycles; only the first 16 fit a frame.
    task automatic feats(input int n, input int ch, input int bank, input string tag);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0);
            check_eq({tag, ".wr_en"}, 64'(wr_en), 64'(i < 16));
            if (i < 16) begin
                check_eq({tag, ".wr_addr"}, 64'(wr_addr), 64'(i));
            end
            check_eq({tag, ".wr_ch"}, 64'(wr_ch), 64'(ch));
            check_eq({tag, ".wr_bank"}, 64'(wr_bank), 64'(bank));
            tick();
        end
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        check_eq("reset.outputs",
                 64'({wr_en, wr_ch, wr_bank, wr_addr, frame_start, set_done, cur_bank,
                      prev_bank, cur_cnt, prev_cnt, cnt_valid, prev_valid, ovf}), 64'd0);

        // Bursts of 100 separated by 4-cycle gaps
        for (int c = 0; c < 212; c++) begin
            drive(!((c >= 100 && c < 104) || (c >= 204 && c < 208)), 1'b0, 1'b0, 1'b0);
            check_eq("t1.frame_start", 64'(frame_start), 64'(c == 0 || c == 104 || c == 208));
            check_eq("t1.set_done", 64'(set_done), 64'(c == 209));
            if (c == 50 || c == 150 || c == 210) begin
                check_eq("t1.ch_idx", 64'(wr_ch), 64'(c == 150));
            end
            if (c == 209) begin
                check_eq("t1.cnt_valid", 64'(cnt_valid), 64'd1);
            end
            tick();
        end

        // A 3-cycle hole is shorter than GAP_MIN and keeps the frame
        do_reset();
        for (int c = 0; c < 29; c++) begin
            drive(!((c >= 10 && c < 13) || (c >= 23 && c < 27)), 1'b0, 1'b0, 1'b0);
            check_eq("t2.frame_start", 64'(frame_start), 64'(c == 0 || c == 27));
            if (c == 20 || c == 28) begin
                check_eq("t2.ch_idx", 64'(wr_ch), 64'(c == 28));
            end
            tick();
        end

        // 7 + 12 features, then a second set of 3 + 1
        do_reset();
        start("t3.s0c0");
        feats(7, 0, 0, "t3.s0c0");
        gap(4);
        start("t3.s0c1");
        feats(12, 1, 0, "t3.s0c1");
        gap(4);
        start("t3.s1c0");
        check_eq("t3.set_done", 64'(set_done), 64'd1);
        check_eq("t3.cur_cnt", 64'(cur_cnt), 64'd391);
        check_eq("t3.cur_bank", 64'(cur_bank), 64'd0);
        check_eq("t3.cnt_valid", 64'(cnt_valid), 64'd1);
        check_eq("t3.prev_valid", 64'(prev_valid), 64'd0);
        feats(3, 0, 1, "t3.s1c0");
        gap(4);
        start("t3.s1c1");
        feats(1, 1, 1, "t3.s1c1");
        gap(4);
        start("t3.s2c0");
        check_eq("t3.set_done2", 64'(set_done), 64'd1);
        check_eq("t3.cur_bank2", 64'(cur_bank), 64'd1);
        check_eq("t3.prev_bank2", 64'(prev_bank), 64'd0);
        check_eq("t3.prev_valid2", 64'(prev_valid), 64'd1);
        check_eq("t3.cur_cnt2", 64'(cur_cnt), 64'd35);
        check_eq("t3.prev_cnt2", 64'(prev_cnt), 64'd391);

        // Saturation at 16 features and overflow flag handling
        do_reset();
        start("t4");
        feats(20, 0, 0, "t4");
        check_eq("t4.ovf_set", 64'(ovf), 64'd1);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        check_eq("t4.ovf_clr", 64'(ovf), 64'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        check_eq("t4.sat_wr_en", 64'(wr_en), 64'd0);
        tick();
        check_eq("t4.ovf_set_wins", 64'(ovf), 64'd1);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        check_eq("t4.flush_done", 64'(set_done), 64'd1);
        check_eq("t4.cur_cnt", 64'(cur_cnt), 64'd16);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // Six sets walk the five-slot ring
        do_reset();
        for (int s = 0; s <= 6; s++) begin
            start("t5.c0");
            if (s > 0) begin
                check_eq("t5.set_done", 64'(set_done), 64'd1);
                check_eq("t5.cur_bank", 64'(cur_bank), 64'((s - 1) % 5));
                check_eq("t5.safe_cur", 64'(wr_bank == cur_bank), 64'd0);
            end
            if (s > 1) begin
                check_eq("t5.safe_prev", 64'(wr_bank == prev_bank), 64'd0);
            end
            if (s < 6) begin
                feats(1, 0, s % 5, "t5.c0");
                gap(4);
                start("t5.c1");
                feats(1, 1, s % 5, "t5.c1");
                gap(4);
            end
        end

        // Flush in IDLE is ignored; flush during ch1 commits the partial set
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check_eq("t6.idle_flush_done", 64'(set_done), 64'd0);
        check_eq("t6.idle_flush_valid", 64'(cnt_valid), 64'd0);
        start("t6.c0");
        feats(2, 0, 0, "t6.c0");
        gap(4);
        start("t6.c1");
        feats(5, 1, 0, "t6.c1");
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check_eq("t6.flush_done", 64'(set_done), 64'd1);
        check_eq("t6.flush_cnt", 64'(cur_cnt), 64'd162);
        check_eq("t6.flush_bank", 64'(cur_bank), 64'd0);
        gap(1);
        start("t6.next");
        check_eq("t6.no_extra_commit", 64'(set_done), 64'd0);
        check_eq("t6.cur_bank_held", 64'(cur_bank), 64'd0);
        feats(1, 0, 1, "t6.next");

        // Reset mid-frame clears every output
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_eq("t6.rst_outputs",
                 64'({wr_en, wr_ch, wr_bank, wr_addr, frame_start, set_done, cur_bank,
                      prev_bank, cur_cnt, prev_cnt, cnt_valid, prev_valid, ovf}), 64'd0);
        rst = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
